// File: rtl/adder.sv
// Registered WIDTH-bit two's-complement adder/subtractor on two-level carry-lookahead logic.
// Cin = 0 adds, Cin = 1 subtracts (A + ~B + 1). Results appear one clock after the operands.
module adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] be_add_number,
  input  logic [WIDTH-1:0] tmp,
  input  logic             Cin,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             overflow
);

  localparam int NumGroups = (WIDTH + 3) / 4;

  // Flattened lookahead carry into position n:
  //   cin & p[0..n-1]  |  OR_k ( g[k] & p[k+1..n-1] )
  // Only indices below n are used, so callers may pass shifted or padded vectors.
  function automatic logic la_carry(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] p,
                                    input logic cin, input int n);
    logic c;
    logic prop;
    c = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (k < n) begin
        prop = 1'b1;
        for (int m = 0; m < WIDTH; m++) begin
          if (m > k && m < n) prop = prop & p[m];
        end
        c = c | (g[k] & prop);
      end
    end
    prop = cin;
    for (int m = 0; m < WIDTH; m++) begin
      if (m < n) prop = prop & p[m];
    end
    return c | prop;
  endfunction

  logic [WIDTH-1:0]     bx;
  logic [WIDTH-1:0]     g;
  logic [WIDTH-1:0]     p;
  logic [WIDTH:0]       c;
  logic [WIDTH-1:0]     s;
  logic [NumGroups-1:0] grp_g;
  logic [NumGroups-1:0] grp_p;
  logic [NumGroups:0]   grp_c;
  logic [WIDTH-1:0]     grp_g_ext;
  logic [WIDTH-1:0]     grp_p_ext;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Operand conditioning and per-bit generate/propagate.
  always_comb begin
    bx = tmp ^ {WIDTH{Cin}};
    g  = be_add_number & bx;
    p  = be_add_number ^ bx;
  end

  // Group-level vectors padded to WIDTH so the same lookahead function serves both levels.
  assign grp_g_ext = {{(WIDTH - NumGroups){1'b0}}, grp_g};
  assign grp_p_ext = {{(WIDTH - NumGroups){1'b0}}, grp_p};

  // Second level: every group carry-in comes straight from group G/P and Cin, no ripple.
  for (genvar j = 0; j <= NumGroups; j++) begin : gen_grp_carry
    assign grp_c[j] = la_carry(grp_g_ext, grp_p_ext, Cin, j);
  end

  for (genvar j = 0; j < NumGroups; j++) begin : gen_group
    localparam int Base = 4 * j;
    localparam int Len  = (WIDTH - Base < 4) ? (WIDTH - Base) : 4;

    assign grp_g[j] = la_carry(g >> Base, p >> Base, 1'b0, Len);
    assign grp_p[j] = &p[Base+Len-1:Base];

    for (genvar i = 0; i < Len; i++) begin : gen_bit
      assign c[Base+i] = la_carry(g >> Base, p >> Base, grp_c[j], i);
    end
  end

  assign c[WIDTH] = grp_c[NumGroups];

  // Sum bits and next-state values for the output registers.
  always_comb begin
    s      = p ^ c[WIDTH-1:0];
    sum_d  = s;
    cout_d = c[WIDTH];
    ovf_d  = c[WIDTH] ^ c[WIDTH-1];
  end

  // Output registers; reset clears them immediately and discards the pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign Cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder (WIDTH = 4): directed boundary cases, exhaustive sweep,
// random vectors against an arithmetic reference model, and asynchronous reset checks.
module tb_adder;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  int n_vec;
  int n_err;

  adder #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .be_add_number(a),
    .tmp          (b),
    .Cin          (cin),
    .sum          (sum),
    .Cout         (cout),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mc,
                       output logic [WIDTH-1:0] es, output logic ec, output logic eo);
    int ua, ub, total, sa, sb, sres;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    if (mc) begin
      total = ua + (15 - ub) + 1;
      sres  = sa - sb;
    end else begin
      total = ua + ub;
      sres  = sa + sb;
    end
    es = WIDTH'(total % 16);
    ec = (total >= 16);
    eo = (sres > 7) || (sres < -8);
  endtask

  // Drive one vector just after a rising edge, sample the registered result after the next.
  task automatic apply(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic tc);
    logic [WIDTH-1:0] es;
    logic ec, eo;
    model(ta, tb, tc, es, ec, eo);
    a   = ta;
    b   = tb;
    cin = tc;
    @(posedge clk);
    #1;
    check({tag, ".sum"}, 32'(sum), 32'(es));
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".ovf"}, 32'(overflow), 32'(eo));
  endtask

  task automatic check_clear(input string tag);
    check({tag, ".sum"}, 32'(sum), 32'd0);
    check({tag, ".cout"}, 32'(cout), 32'd0);
    check({tag, ".ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    a     = 4'b0111;
    b     = 4'b0001;
    cin   = 1'b0;

    // Reset held with arbitrary inputs across several edges.
    #2;
    check_clear("rst_pre");
    repeat (3) @(posedge clk);
    #1;
    check_clear("rst_hold");
    rst_n = 1'b1;

    // Directed cases from the specification (literal expectations).
    a = 4'b0000; b = 4'b1000; cin = 1'b0;
    @(posedge clk); #1;
    check("add0.sum", 32'(sum), 32'h8);
    check("add0.cout", 32'(cout), 32'd0);
    check("add0.ovf", 32'(overflow), 32'd0);

    a = 4'b1111; b = 4'b1000; cin = 1'b1;
    @(posedge clk); #1;
    check("sub0.sum", 32'(sum), 32'h7);
    check("sub0.cout", 32'(cout), 32'd1);
    check("sub0.ovf", 32'(overflow), 32'd0);

    a = 4'b0111; b = 4'b0001; cin = 1'b0;
    @(posedge clk); #1;
    check("ovf_add.sum", 32'(sum), 32'h8);
    check("ovf_add.cout", 32'(cout), 32'd0);
    check("ovf_add.ovf", 32'(overflow), 32'd1);

    a = 4'b1000; b = 4'b1000; cin = 1'b0;
    @(posedge clk); #1;
    check("ovf_neg.sum", 32'(sum), 32'h0);
    check("ovf_neg.cout", 32'(cout), 32'd1);
    check("ovf_neg.ovf", 32'(overflow), 32'd1);

    a = 4'b1000; b = 4'b0001; cin = 1'b1;
    @(posedge clk); #1;
    check("ovf_sub.sum", 32'(sum), 32'h7);
    check("ovf_sub.cout", 32'(cout), 32'd1);
    check("ovf_sub.ovf", 32'(overflow), 32'd1);

    a = 4'b0000; b = 4'b0001; cin = 1'b1;
    @(posedge clk); #1;
    check("borrow.sum", 32'(sum), 32'hf);
    check("borrow.cout", 32'(cout), 32'd0);
    check("borrow.ovf", 32'(overflow), 32'd0);

    a = 4'b0101; b = 4'b0101; cin = 1'b1;
    @(posedge clk); #1;
    check("self_sub.sum", 32'(sum), 32'h0);
    check("self_sub.cout", 32'(cout), 32'd1);
    check("self_sub.ovf", 32'(overflow), 32'd0);

    // Exhaustive sweep against the reference model.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      apply("exh", v[3:0], v[7:4], v[8]);
    end

    // Random vectors.
    for (int i = 0; i < 200; i++) begin
      apply("rnd", 4'($urandom), 4'($urandom), 1'($urandom));
    end

    // Asynchronous clear between edges with a nonzero result registered.
    apply("pre_async", 4'b0111, 4'b0001, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_clear("async_clr");
    a = 4'b1010; b = 4'b0110; cin = 1'b0;
    @(posedge clk); #1;
    check_clear("async_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst.sum", 32'(sum), 32'h0);
    check("post_rst.cout", 32'(cout), 32'd1);
    check("post_rst.ovf", 32'(overflow), 32'd0);

    apply("tail", 4'b0011, 4'b0100, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
